serial_adder_engine: RTL and testbench
======================================

// Module: serial_adder_engine
// PURPOSE
//  Parametrised multi-cycle add/subtract engine. Processes DIGIT bits per cycle over WIDTH-bit operands.
//  Ripple carry is held in a register between digits; supports add-with-carry and subtract-with-borrow.
//  Valid/ready handshake on both sides, so it sits between the tile input capture logic and the result mux.
//  Trades latency for area compared with a flat combinational adder.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; >=2
//  DIGIT  1  bits processed per cycle; WIDTH % DIGIT must be 0, otherwise elaboration error
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  ena        in   1      clock-enable; 0 freezes all state
//  in_valid   in   1      operand set valid
//  in_ready   out  1      engine can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin; 1: a-b-cin
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  result, mod 2^WIDTH
//  cout       out  1      carry-out (add) / borrow-out (sub)
//  ovf        out  1      two's-complement overflow
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=IDLE; out_valid=0, sum=0, cout=0, ovf=0; digit counter=0.
//   - Reset mid-RUN or mid-DONE aborts the operation; no result is produced.
//  Constants: N = WIDTH/DIGIT.
//  in_ready = ena & (state==IDLE | (state==DONE & out_ready)); combinational.
//  Accept = in_valid & in_ready:
//   - Load shift regs A=a, B = sub ? ~b : b, carry = sub ? ~cin : cin.
//   - Capture sub; counter=0; go to RUN.
//  RUN (one digit per ena cycle):
//   - Add DIGIT LSBs of A and B plus carry.
//   - Shift the digit result into the top of the result register; shift A and B right by DIGIT.
//   - Update carry; on the last digit (counter==N-1) also record carry-into-MSB; counter++.
//  Last digit: go to DONE next edge and update the outputs together:
//   - sum = result register.
//   - cout = sub ? ~carry_out : carry_out.
//   - ovf = carry_into_MSB ^ carry_out.
//   - out_valid = 1.
//  Latency: accept at edge t gives out_valid=1 after edge t+N (ena held high).
//  DONE:
//   - out_valid, sum, cout, ovf held stable while out_ready=0.
//   - out_ready=1 (with ena=1): IDLE, or RUN if a new accept occurs in the same cycle (back-to-back).
//  sum, cout, ovf change only on DONE entry or reset; otherwise they hold the last result.
//  ena=0:
//   - No state, counter, carry or output change; in_ready=0.
//   - Each low cycle during RUN adds exactly one cycle of latency.
//   - While ena=0, out_ready is ignored.
//  in_valid while busy (RUN): ignored, in_ready=0. Operand inputs are sampled only at accept.
//  Results are modulo 2^WIDTH; no saturation.
// STRUCTURE
//  Package serial_adder_pkg: state encoding localparams (ST_IDLE, ST_RUN, ST_DONE).
//  Package also holds clog2-based counter-width helper.
//  Sub-module digit_adder: combinational DIGIT-bit ripple of full-adder cells.
//   - Inputs: a_d, b_d, c_in.
//   - Outputs: s_d, c_out, c_msb (carry into top bit).
//   - Instantiated once.
//  Top: FSM, counter, A/B/result shift registers, carry register, output registers.
// TESTING
//  1. W=8,D=1: a=0x5A, b=0x3C, cin=1, sub=0 -> after 8 cycles sum=0x97, cout=0, ovf=1.
//  2. W=8,D=1: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0.
//  3. Subtract, a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=1, ovf=0.
//     Subtract, a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=0, ovf=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles -> out_valid=1 and sum stable, in_ready=0.
//     Then out_ready=1 and in_valid=1 in the same cycle -> new op accepted, out_valid=0 next edge.
//     Second result arrives N cycles later.
//  5. Reset mid-RUN: assert rst_n=0 at digit 3 -> next edge out_valid=0, sum=0, in_ready=1 (ena=1).
//     No stale result appears afterwards.
//  6. W=16,D=4, ena low 2 cycles during RUN -> latency 6.
//     Then 1000 random ops vs {cout,sum} model with back-to-back accepts and random out_ready.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and counter sizing for the serial adder engine
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Digit counter must hold 0..n-1; a single-digit engine still needs one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple of full-adder cells
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s_d  = '0;
        c[0] = c_in;
        for (int i = 0; i < DIGIT; i++) begin
            s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
            c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
        end
    end

    assign c_out = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_engine.sv
// rtl/serial_adder_engine.sv - multi-cycle add/subtract engine processing DIGIT bits per cycle
module serial_adder_engine
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder_engine: WIDTH must be >=2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             sub_q;
    logic [DIGIT-1:0] s_d;
    logic             c_out;
    logic             c_msb;
    logic             accept;
    logic             last;

    assign in_ready = ena & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign last     = (cnt == CW'(N - 1));

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_d   (a_sr[DIGIT-1:0]),
        .b_d   (b_sr[DIGIT-1:0]),
        .c_in  (carry),
        .s_d   (s_d),
        .c_out (c_out),
        .c_msb (c_msb)
    );

    // New digit enters at the top so the full result is LSB-aligned after N shifts.
    assign res_next = (res_sr >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry     <= 1'b0;
            sub_q     <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (ena) begin
            if (accept) begin
                // Subtraction runs as a + ~b + ~cin; borrow is the inverted carry.
                a_sr      <= a;
                b_sr      <= sub ? ~b : b;
                carry     <= sub ? ~cin : cin;
                sub_q     <= sub;
                cnt       <= '0;
                state     <= ST_RUN;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    ST_RUN: begin
                        a_sr   <= a_sr >> DIGIT;
                        b_sr   <= b_sr >> DIGIT;
                        res_sr <= res_next;
                        carry  <= c_out;
                        cnt    <= cnt + 1'b1;
                        if (last) begin
                            state     <= ST_DONE;
                            sum       <= res_next;
                            cout      <= sub_q ^ c_out;
                            ovf       <= c_msb ^ c_out;
                            out_valid <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    ST_IDLE: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_engine.sv
// tb/tb_serial_adder_engine.sv - self-checking bench for serial_adder_engine (W8/D1 and W16/D4)
module tb_serial_adder_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       ena8, in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic        ena16, in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    serial_adder_engine #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder_engine #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena16), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic sb);
        int unsigned ua, ub, ur;
        int          sa, sbv, sr;
        logic [15:0] s;
        logic        co, ov;
        ua  = a;
        ub  = b;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (!sb) begin
            ur = ua + ub + ci;
            co = (ur > 65535);
            sr = sa + sbv + int'(ci);
        end else begin
            ur = ua - ub - ci;
            co = (ua < ub + ci);
            sr = sa - sbv - int'(ci);
        end
        s  = ur[15:0];
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, s};
    endfunction

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sb, output int lat);
        a8 = a; b8 = b; cin8 = ci; sub8 = sb; in_valid8 = 1'b1; out_ready8 = 1'b0;
        for (int k = 0; k < 20 && !in_ready8; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (out_valid8) begin
                lat = k - 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (out_valid8 && lat < 0) lat = 100;
    endtask

    task automatic consume8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t        vecs[6];
    logic [17:0] q[$];
    logic [17:0] exp16;
    logic [7:0]  held;
    int          lat, accepted, cycles;
    logic        stale;

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        ena8 = 1'b1; in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b0;
        ena16 = 1'b1; in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid8), 32'd0);
        check("reset_sum", 32'(sum8), 32'd0);
        check("reset_cout_ovf", 32'({cout8, ovf8}), 32'd0);
        check("reset_in_ready", 32'(in_ready8), 32'd1);
        check("reset_out_valid16", 32'(out_valid16), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_sum", i), 32'(sum8), 32'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 32'(cout8), 32'(vecs[i].co));
            check($sformatf("vec%0d_ovf", i), 32'(ovf8), 32'(vecs[i].ov));
            consume8();
        end

        // Backpressure, then back-to-back accept in the releasing cycle.
        do_op8(8'h11, 8'h22, 1'b0, 1'b0, lat);
        held = sum8;
        check("bp_first_sum", 32'(held), 32'h33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid_held", 32'(out_valid8), 32'd1);
            check("bp_sum_stable", 32'(sum8), 32'(held));
            check("bp_in_ready_low", 32'(in_ready8), 32'd0);
        end
        a8 = 8'h40; b8 = 8'h05; cin8 = 1'b1; sub8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready8), 32'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        check("b2b_out_valid_drop", 32'(out_valid8), 32'd0);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (out_valid8) begin
                lat = k;
                break;
            end
        end
        check("b2b_latency", 32'(lat), 32'd8);
        check("b2b_result", 32'({cout8, ovf8, sum8}), 32'({1'b0, 1'b0, 8'h3A}));
        consume8();

        // Reset in the middle of RUN.
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_run_out_valid", 32'(out_valid8), 32'd0);
        check("rst_run_sum", 32'(sum8), 32'd0);
        check("rst_run_in_ready", 32'(in_ready8), 32'd1);
        rst_n = 1'b1;
        out_ready8 = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid8) stale = 1'b1;
        end
        check("rst_run_no_stale", 32'(stale), 32'd0);
        out_ready8 = 1'b0;

        // W16/D4: two ena-low cycles during RUN stretch latency from 4 to 6.
        a16 = 16'h1234; b16 = 16'h0FF1; cin16 = 1'b1; sub16 = 1'b0; in_valid16 = 1'b1;
        out_ready16 = 1'b0; ena16 = 1'b1;
        #1;
        check("ena_in_ready_idle", 32'(in_ready16), 32'd1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            ena16 = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (out_valid16) begin
                lat = k;
                break;
            end
        end
        check("ena_latency", 32'(lat), 32'd6);
        exp16 = model16(16'h1234, 16'h0FF1, 1'b1, 1'b0);
        check("ena_result", 32'({ovf16, cout16, sum16}), 32'(exp16));
        ena16 = 1'b0; out_ready16 = 1'b1;
        #1;
        check("ena_low_in_ready", 32'(in_ready16), 32'd0);
        @(posedge clk); #1;
        check("ena_low_ignores_out_ready", 32'(out_valid16), 32'd1);
        ena16 = 1'b1;
        @(posedge clk); #1;
        check("ena_high_consumes", 32'(out_valid16), 32'd0);
        out_ready16 = 1'b0;

        // Random traffic against the arithmetic model.
        accepted = 0;
        cycles = 0;
        while ((accepted < 1000 || q.size() != 0) && cycles < 40000) begin
            @(posedge clk); #1;
            cycles++;
            if (accepted < 1000) begin
                ena16       = ($urandom_range(0, 7) != 0);
                out_ready16 = ($urandom_range(0, 2) != 0);
                in_valid16  = ($urandom_range(0, 3) != 0);
                a16   = 16'($urandom);
                b16   = 16'($urandom);
                cin16 = 1'($urandom);
                sub16 = 1'($urandom);
            end else begin
                ena16 = 1'b1; out_ready16 = 1'b1; in_valid16 = 1'b0;
            end
            @(negedge clk);
            if (ena16 && out_valid16 && out_ready16) begin
                if (q.size() == 0) begin
                    check("rand_spurious_result", 32'd1, 32'd0);
                end else begin
                    exp16 = q.pop_front();
                    check("rand_result", 32'({ovf16, cout16, sum16}), 32'(exp16));
                end
            end
            if (in_valid16 && in_ready16) begin
                q.push_back(model16(a16, b16, cin16, sub16));
                accepted++;
            end
        end
        check("rand_all_drained", 32'(accepted >= 1000 && q.size() == 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
